// File: rtl/systolic_skew_feeder_pkg.sv
// Shared types and defaults for the skewed systolic-array feeder.
// Optional performance counters are enabled with SKEW_FEEDER_PERF_EN.
package systolic_skew_feeder_pkg;

  typedef enum logic [1:0] {
    FDR_IDLE = 2'd0,
    FDR_RUN  = 2'd1,
    FDR_DONE = 2'd2
  } fdr_state_e;

  localparam int DEF_ROWS  = 8;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_DW    = 16;

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/systolic_skew_feeder_if.sv
// Loader/consumer-side bus of the skew feeder: buffer write port, run launch and
// skewed activation/weight lanes with per-row done.
interface systolic_skew_feeder_if
  import systolic_skew_feeder_pkg::*;
#(
  parameter int ROWS  = DEF_ROWS,
  parameter int DEPTH = DEF_DEPTH,
  parameter int DW    = DEF_DW
);
  localparam int RW = idx_width(ROWS);
  localparam int IW = idx_width(DEPTH);

  logic                 wr_en;
  logic [RW-1:0]        wr_row;
  logic [IW-1:0]        wr_idx;
  logic [DW-1:0]        wr_act;
  logic [DW-1:0]        wr_wgt;
  logic                 start;
  logic [ROWS*DW-1:0]   activations;
  logic [ROWS*DW-1:0]   weights;
  logic [ROWS-1:0]      done;
  logic                 busy;
  logic                 finished;

  modport master (
    output wr_en, wr_row, wr_idx, wr_act, wr_wgt, start,
    input  activations, weights, done, busy, finished
  );

  modport slave (
    input  wr_en, wr_row, wr_idx, wr_act, wr_wgt, start,
    output activations, weights, done, busy, finished
  );

endinterface

// File: rtl/systolic_skew_feeder_row_lane.sv
// One array row: DEPTH-entry act/wgt buffer, registered skewed output mux and
// sticky done bit. ROW is the lane's skew offset in cycles.
module systolic_skew_feeder_row_lane #(
  parameter int DEPTH = 4,
  parameter int DW    = 16,
  parameter int ROW   = 0,
  parameter int TW    = 4,
  parameter int IW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          launch,
  input  logic          run,
  input  logic [TW-1:0] t,
  input  logic          wr_sel,
  input  logic [IW-1:0] wr_idx,
  input  logic [DW-1:0] wr_act,
  input  logic [DW-1:0] wr_wgt,
  output logic [DW-1:0] act,
  output logic [DW-1:0] wgt,
  output logic          done
);

  localparam logic [TW-1:0] ROW_T   = TW'(ROW);
  localparam logic [TW-1:0] DEPTH_T = TW'(DEPTH);

  logic [2*DW-1:0] mem [DEPTH];
  logic [TW-1:0]   k;
  logic            past_row;
  logic            in_win;
  logic            at_end;

  // k = t - ROW is only meaningful once t has reached this row's offset.
  assign k        = t - ROW_T;
  assign past_row = (t >= ROW_T);
  assign in_win   = past_row && (k < DEPTH_T);
  assign at_end   = past_row && (k == DEPTH_T);

  // Buffer contents survive reset; the caller always reloads before a run.
  always_ff @(posedge clk) begin
    if (en && wr_sel) begin
      mem[wr_idx] <= {wr_act, wr_wgt};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act  <= '0;
      wgt  <= '0;
      done <= 1'b0;
    end else if (en) begin
      if (run && in_win) begin
        {act, wgt} <= mem[k[IW-1:0]];
      end else begin
        act <= '0;
        wgt <= '0;
      end
      if (launch) begin
        done <= 1'b0;
      end else if (run && at_end) begin
        done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Skewed activation/weight feeder for the PE cluster: buffers ROWS x DEPTH pairs,
// streams row r delayed r cycles. Define SKEW_FEEDER_PERF_EN for run/stall counters.
module systolic_skew_feeder
  import systolic_skew_feeder_pkg::*;
#(
  parameter int ROWS  = DEF_ROWS,
  parameter int DEPTH = DEF_DEPTH,
  parameter int DW    = DEF_DW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  systolic_skew_feeder_if.slave bus
`ifdef SKEW_FEEDER_PERF_EN
  ,
  output logic [31:0]          run_cycles,
  output logic [31:0]          stall_cycles
`endif
);

  localparam int RW = idx_width(ROWS);
  localparam int IW = idx_width(DEPTH);
  localparam int TW = $clog2(ROWS + DEPTH + 1);

  localparam logic [TW-1:0] LAST_T  = TW'(ROWS + DEPTH - 1);
  localparam logic [RW:0]   ROWS_L  = (RW + 1)'(ROWS);
  localparam logic [IW:0]   DEPTH_L = (IW + 1)'(DEPTH);

  fdr_state_e           state, state_nxt;
  logic [TW-1:0]        t, t_nxt;
  logic                 running;
  logic                 last;
  logic                 launch;
  logic                 wr_ok;
  logic                 finished_q;
  logic [ROWS-1:0][DW-1:0] act_q;
  logic [ROWS-1:0][DW-1:0] wgt_q;
  logic [ROWS-1:0]      done_q;

  assign running = (state == FDR_RUN);
  assign last    = running && (t == LAST_T);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FDR_IDLE;
      t     <= '0;
    end else begin
      state <= state_nxt;
      t     <= t_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    t_nxt     = t;
    launch    = 1'b0;
    if (en) begin
      unique case (state)
        FDR_IDLE, FDR_DONE: begin
          if (bus.start) begin
            state_nxt = FDR_RUN;
            t_nxt     = '0;
            launch    = 1'b1;
          end
        end
        FDR_RUN: begin
          if (last) begin
            state_nxt = FDR_DONE;
          end else begin
            t_nxt = t + 1'b1;
          end
        end
        default: state_nxt = FDR_IDLE;
      endcase
    end
  end

  // A write in the launch cycle lands before the first RUN edge reads the buffer.
  assign wr_ok = en && bus.wr_en && !running
                 && ({1'b0, bus.wr_row} < ROWS_L)
                 && ({1'b0, bus.wr_idx} < DEPTH_L);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      finished_q <= 1'b0;
    end else if (en) begin
      finished_q <= last;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    systolic_skew_feeder_row_lane #(
      .DEPTH (DEPTH),
      .DW    (DW),
      .ROW   (r),
      .TW    (TW),
      .IW    (IW)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .launch (launch),
      .run    (running),
      .t      (t),
      .wr_sel (wr_ok && (bus.wr_row == RW'(r))),
      .wr_idx (bus.wr_idx),
      .wr_act (bus.wr_act),
      .wr_wgt (bus.wr_wgt),
      .act    (act_q[r]),
      .wgt    (wgt_q[r]),
      .done   (done_q[r])
    );
  end

  assign bus.activations = act_q;
  assign bus.weights     = wgt_q;
  assign bus.done        = done_q;
  assign bus.busy        = running;
  assign bus.finished    = finished_q;

`ifdef SKEW_FEEDER_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cycles   <= '0;
      stall_cycles <= '0;
    end else if (running) begin
      if (en) begin
        run_cycles <= run_cycles + 32'd1;
      end else begin
        stall_cycles <= stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench for systolic_skew_feeder: scoreboarded skewed stream for an
// 8x4 instance plus a 1x1 instance for the single-row/single-element corner.
module tb_systolic_skew_feeder;
  import systolic_skew_feeder_pkg::*;

  localparam int ROWS  = 8;
  localparam int DEPTH = 4;
  localparam int DW    = 16;
  localparam int RW    = 3;
  localparam int IW    = 2;
  localparam int W     = ROWS * DW;
  localparam int LASTT = ROWS + DEPTH - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic en;

  always #5 clk = ~clk;

  systolic_skew_feeder_if #(.ROWS(ROWS), .DEPTH(DEPTH), .DW(DW)) bus ();
  systolic_skew_feeder_if #(.ROWS(1), .DEPTH(1), .DW(DW)) sif ();

`ifdef SKEW_FEEDER_PERF_EN
  logic [31:0] run_cycles, stall_cycles, s_run_cycles, s_stall_cycles;
  systolic_skew_feeder #(.ROWS(ROWS), .DEPTH(DEPTH), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .bus(bus.slave),
    .run_cycles(run_cycles), .stall_cycles(stall_cycles));
  systolic_skew_feeder #(.ROWS(1), .DEPTH(1), .DW(DW)) dut_small (
    .clk(clk), .rst_n(rst_n), .en(en), .bus(sif.slave),
    .run_cycles(s_run_cycles), .stall_cycles(s_stall_cycles));
`else
  systolic_skew_feeder #(.ROWS(ROWS), .DEPTH(DEPTH), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .bus(bus.slave));
  systolic_skew_feeder #(.ROWS(1), .DEPTH(1), .DW(DW)) dut_small (
    .clk(clk), .rst_n(rst_n), .en(en), .bus(sif.slave));
`endif

  typedef struct {
    logic [W-1:0]    act;
    logic [W-1:0]    wgt;
    logic [ROWS-1:0] done;
    logic            busy;
    logic            fin;
  } rec_t;

  typedef struct {
    string name;
    int    stall_t;
    int    stall_len;
    int    start_t;
    int    exp_fin;
  } scen_t;

  int total = 0;
  int bad   = 0;
  int ncyc  = 0;

  // Reference model state
  logic [DW-1:0] m_act [ROWS][DEPTH];
  logic [DW-1:0] m_wgt [ROWS][DEPTH];
  rec_t cur;
  bit   mrun;
  int   mt;
  rec_t sbq [$];

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    ncyc++;
  endtask

  task automatic model_reset();
    cur.act  = '0;
    cur.wgt  = '0;
    cur.done = '0;
    cur.busy = 1'b0;
    cur.fin  = 1'b0;
    mrun     = 1'b0;
    mt       = 0;
  endtask

  task automatic model_edge(input logic e, input logic st, input logic we,
                            input int row, input int idx,
                            input logic [DW-1:0] a, input logic [DW-1:0] w);
    int k;
    if (!e) return;
    if (we && !mrun && row < ROWS && idx < DEPTH) begin
      m_act[row][idx] = a;
      m_wgt[row][idx] = w;
    end
    if (!mrun) begin
      cur.act = '0;
      cur.wgt = '0;
      cur.fin = 1'b0;
      cur.busy = st;
      if (st) begin
        cur.done = '0;
        mrun = 1'b1;
        mt = 0;
      end
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        k = mt - r;
        if (k >= 0 && k < DEPTH) begin
          cur.act[r*DW +: DW] = m_act[r][k];
          cur.wgt[r*DW +: DW] = m_wgt[r][k];
        end else begin
          cur.act[r*DW +: DW] = '0;
          cur.wgt[r*DW +: DW] = '0;
        end
        if (k == DEPTH) cur.done[r] = 1'b1;
      end
      cur.fin  = (mt == LASTT);
      cur.busy = !cur.fin;
      if (cur.fin) mrun = 1'b0;
      mt++;
    end
  endtask

  task automatic drive(input logic e, input logic st, input logic we,
                       input int row, input int idx,
                       input logic [DW-1:0] a, input logic [DW-1:0] w);
    rec_t exp;
    en         = e;
    bus.start  = st;
    bus.wr_en  = we;
    bus.wr_row = RW'(row);
    bus.wr_idx = IW'(idx);
    bus.wr_act = a;
    bus.wr_wgt = w;
    model_edge(e, st, we, row, idx, a, w);
    sbq.push_back(cur);
    tick();
    exp = sbq.pop_front();
    chk($sformatf("act@%0d", ncyc), bus.activations, exp.act);
    chk($sformatf("wgt@%0d", ncyc), bus.weights, exp.wgt);
    chk($sformatf("done@%0d", ncyc), W'(bus.done), W'(exp.done));
    chk($sformatf("busy@%0d", ncyc), W'(bus.busy), W'(exp.busy));
    chk($sformatf("fin@%0d", ncyc), W'(bus.finished), W'(exp.fin));
  endtask

  task automatic run_scen(input scen_t s);
    int  c;
    int  stalled;
    bit  seen;
    logic e, st, we;
    drive(1'b1, 1'b1, 1'b0, 0, 0, '0, '0);
    c = 0;
    stalled = 0;
    seen = 1'b0;
    while (!seen && c < 40) begin
      e = 1'b1;
      st = 1'b0;
      we = 1'b0;
      if (mrun && mt == s.stall_t && stalled < s.stall_len) begin
        e = 1'b0;
        stalled++;
      end
      if (mrun && mt == s.start_t && e) begin
        st = 1'b1;
        we = 1'b1;
      end
      drive(e, st, we, 0, 0, 16'hDEAD, 16'hDEAD);
      c++;
      if (bus.finished === 1'b1) seen = 1'b1;
    end
    chk({s.name, " fin_cycle"}, W'(c), W'(s.exp_fin));
  endtask

  scen_t scen [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    scen[0] = '{"plain",        -1, 0, -1, 12};
    scen[1] = '{"stall",         5, 2, -1, 14};
    scen[2] = '{"start_in_run", -1, 0,  6, 12};
    scen[3] = '{"replay",       -1, 0, -1, 12};

    rst_n = 1'b0;
    en = 1'b0;
    bus.start = 1'b0; bus.wr_en = 1'b0; bus.wr_row = '0; bus.wr_idx = '0;
    bus.wr_act = '0; bus.wr_wgt = '0;
    sif.start = 1'b0; sif.wr_en = 1'b0; sif.wr_row = '0; sif.wr_idx = '0;
    sif.wr_act = '0; sif.wr_wgt = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst act", bus.activations, '0);
    chk("rst wgt", bus.weights, '0);
    chk("rst done", W'(bus.done), '0);
    chk("rst busy", W'(bus.busy), '0);
    chk("rst fin", W'(bus.finished), '0);
    rst_n = 1'b1;

    for (int r = 0; r < ROWS; r++) begin
      for (int k = 0; k < DEPTH; k++) begin
        logic [DW-1:0] a;
        a = {4'(r), 4'(k), 8'h00};
        drive(1'b1, 1'b0, 1'b1, r, k, a, ~a);
      end
    end

    for (int i = 0; i < 4; i++) run_scen(scen[i]);

    // Asynchronous reset in the middle of a run
    drive(1'b1, 1'b1, 1'b0, 0, 0, '0, '0);
    for (int i = 0; i < 40 && mt < 4; i++) drive(1'b1, 1'b0, 1'b0, 0, 0, '0, '0);
    chk("pre-rst busy", W'(bus.busy), W'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    chk("async act", bus.activations, '0);
    chk("async wgt", bus.weights, '0);
    chk("async done", W'(bus.done), '0);
    chk("async busy", W'(bus.busy), '0);
    chk("async fin", W'(bus.finished), '0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run_scen(scen[0]);

    // Write and start together from DONE
    drive(1'b1, 1'b1, 1'b1, 7, 0, 16'hBEEF, 16'h4110);
    chk("done_cleared", W'(bus.done), '0);
    for (int n = 1; n <= LASTT + 1; n++) begin
      drive(1'b1, 1'b0, 1'b0, 0, 0, '0, '0);
      if (n == 8) chk("lane7_beef", W'(bus.activations[7*DW +: DW]), W'(16'hBEEF));
    end

    // Single row, single element instance; out-of-range writes must be dropped
    en = 1'b1;
    bus.start = 1'b0; bus.wr_en = 1'b0;
    sif.wr_en = 1'b1; sif.wr_row = 1'b0; sif.wr_idx = 1'b0;
    sif.wr_act = 16'h1234; sif.wr_wgt = 16'h4321;
    tick();
    sif.wr_row = 1'b1; sif.wr_act = 16'hAAAA; sif.wr_wgt = 16'hAAAA;
    tick();
    sif.wr_row = 1'b0; sif.wr_idx = 1'b1; sif.wr_act = 16'h5555; sif.wr_wgt = 16'h5555;
    tick();
    sif.wr_en = 1'b0; sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    chk("s start busy", W'(sif.busy), W'(1'b1));
    chk("s start act", W'(sif.activations), '0);
    tick();
    chk("s c1 act", W'(sif.activations), W'(16'h1234));
    chk("s c1 wgt", W'(sif.weights), W'(16'h4321));
    chk("s c1 done", W'(sif.done), '0);
    chk("s c1 fin", W'(sif.finished), '0);
    tick();
    chk("s c2 act", W'(sif.activations), '0);
    chk("s c2 done", W'(sif.done), W'(1'b1));
    chk("s c2 fin", W'(sif.finished), W'(1'b1));
    chk("s c2 busy", W'(sif.busy), '0);
`ifdef SKEW_FEEDER_PERF_EN
    chk("s run_cycles", W'(s_run_cycles), W'(32'd2));
`endif
    tick();
    chk("s c3 fin", W'(sif.finished), '0);
    chk("s c3 done", W'(sif.done), W'(1'b1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
